// File: rtl/stepper_axis_driver.sv
// stepper_axis_driver
// Converts per-axis speed/direction words into step/dir pulse trains for two
// stepper drivers (X and Y) and tracks a signed position count per axis.
// Optional feature macro: SOFT_LIMIT_EN (blocks moves beyond +/-POS_LIMIT).
module stepper_axis_driver #(
    parameter int BASE_DIV  = 4,
    parameter int PULSE_W   = 2,
    parameter int DIR_SETUP = 3,
    parameter int SPEED_MAX = 15,
    parameter int POS_W     = 16,
    parameter int POS_LIMIT = 1000
) (
    input  logic                    clock,
    input  logic                    ctrl_reset_n,
    input  logic [31:0]             xSpeed,
    input  logic [31:0]             xDirection,
    input  logic [31:0]             ySpeed,
    input  logic [31:0]             yDirection,
    input  logic                    zero_pos,
    output logic                    step_x,
    output logic                    step_y,
    output logic                    dir_x,
    output logic                    dir_y,
    output logic                    busy_x,
    output logic                    busy_y,
    output logic signed [POS_W-1:0] pos_x,
    output logic signed [POS_W-1:0] pos_y,
    output logic                    limit_x,
    output logic                    limit_y
);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

    localparam logic [31:0] SPEED_CAP = 32'(SPEED_MAX);

    // Axis 0 is X, axis 1 is Y.
    logic [1:0][31:0]      speed_vec;
    logic [1:0]            dir_req_vec;
    logic [1:0]            step_vec;
    logic [1:0]            dir_vec;
    logic [1:0]            busy_vec;
    logic [1:0]            limit_vec;
    logic [1:0][POS_W-1:0] pos_vec;
    logic                  unused_dir_bits;

    assign speed_vec       = {ySpeed, xSpeed};
    assign dir_req_vec     = {yDirection[0], xDirection[0]};
    assign unused_dir_bits = ^{xDirection[31:1], yDirection[31:1]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_axis
            state_t           state_reg;
            logic [31:0]      cnt_reg;
            logic [31:0]      gap_load_reg;
            logic             step_reg;
            logic             dir_reg;
            logic             busy_reg;
            logic [POS_W-1:0] pos_reg;
            logic             limit_reg;

            logic [31:0] speed_eff;
            logic [31:0] period_now;
            logic        at_decision;
            logic        want_move;
            logic        blocked;
            logic        go_pulse;
            logic        go_setup;
            logic        go_idle;

            // Full-width clamp so huge speed words saturate instead of aliasing.
            assign speed_eff  = (speed_vec[gi] > SPEED_CAP) ? SPEED_CAP : speed_vec[gi];
            assign period_now = 32'(BASE_DIV) * (SPEED_CAP + 32'd1 - speed_eff);

            // Decisions happen every IDLE cycle and on the final GAP cycle.
            assign at_decision = (state_reg == IDLE) || ((state_reg == GAP) && (cnt_reg == 32'd0));
            assign want_move   = at_decision && (speed_eff != 32'd0);

`ifdef SOFT_LIMIT_EN
            localparam logic signed [POS_W-1:0] POS_HI = POS_W'(POS_LIMIT);
            localparam logic signed [POS_W-1:0] POS_LO = -POS_HI;

            assign blocked = want_move &&
                             (( dir_req_vec[gi] && ($signed(pos_reg) >= POS_HI)) ||
                              (!dir_req_vec[gi] && ($signed(pos_reg) <= POS_LO)));

            // Limit flag tracks the outcome of the latest moving decision.
            always_ff @(posedge clock) begin
                if (!ctrl_reset_n) begin
                    limit_reg <= 1'b0;
                end else if (zero_pos) begin
                    limit_reg <= 1'b0;
                end else if (want_move) begin
                    limit_reg <= blocked;
                end
            end
`else
            assign blocked   = 1'b0;
            assign limit_reg = 1'b0;
`endif

            assign go_setup = want_move && !blocked && (dir_req_vec[gi] != dir_reg);
            assign go_pulse = (want_move && !blocked && (dir_req_vec[gi] == dir_reg)) ||
                              ((state_reg == SETUP) && (cnt_reg == 32'd0));
            assign go_idle  = at_decision && !go_setup && !go_pulse;

            // Axis sequencer: IDLE -> (SETUP) -> PULSE -> GAP -> decision.
            always_ff @(posedge clock) begin
                if (!ctrl_reset_n) begin
                    state_reg    <= IDLE;
                    cnt_reg      <= 32'd0;
                    gap_load_reg <= 32'd0;
                    step_reg     <= 1'b0;
                    dir_reg      <= 1'b0;
                    busy_reg     <= 1'b0;
                end else if (go_pulse) begin
                    // Period is frozen here so speed changes only act at the next decision.
                    state_reg    <= PULSE;
                    step_reg     <= 1'b1;
                    busy_reg     <= 1'b1;
                    cnt_reg      <= 32'(PULSE_W - 1);
                    gap_load_reg <= period_now - 32'(PULSE_W + 1);
                end else if (go_setup) begin
                    state_reg <= SETUP;
                    dir_reg   <= dir_req_vec[gi];
                    step_reg  <= 1'b0;
                    busy_reg  <= 1'b1;
                    cnt_reg   <= 32'(DIR_SETUP - 1);
                end else if (go_idle) begin
                    state_reg <= IDLE;
                    step_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    cnt_reg   <= 32'd0;
                end else if ((state_reg == PULSE) && (cnt_reg == 32'd0)) begin
                    state_reg <= GAP;
                    step_reg  <= 1'b0;
                    cnt_reg   <= gap_load_reg;
                end else begin
                    cnt_reg <= cnt_reg - 32'd1;
                end
            end

            // Position counter; a coincident clear beats the step count.
            always_ff @(posedge clock) begin
                if (!ctrl_reset_n) begin
                    pos_reg <= '0;
                end else if (zero_pos) begin
                    pos_reg <= '0;
                end else if (go_pulse) begin
                    pos_reg <= dir_reg ? (pos_reg + POS_W'(1)) : (pos_reg - POS_W'(1));
                end
            end

            assign step_vec[gi]  = step_reg;
            assign dir_vec[gi]   = dir_reg;
            assign busy_vec[gi]  = busy_reg;
            assign pos_vec[gi]   = pos_reg;
            assign limit_vec[gi] = limit_reg;
        end
    endgenerate

    assign step_x  = step_vec[0];
    assign step_y  = step_vec[1];
    assign dir_x   = dir_vec[0];
    assign dir_y   = dir_vec[1];
    assign busy_x  = busy_vec[0];
    assign busy_y  = busy_vec[1];
    assign pos_x   = pos_vec[0];
    assign pos_y   = pos_vec[1];
    assign limit_x = limit_vec[0];
    assign limit_y = limit_vec[1];

endmodule

// File: tb/tb_stepper_axis_driver.sv
// Directed testbench for stepper_axis_driver (default parameters, POS_LIMIT=3).
// A second narrow instance (POS_W=4) exercises position wrap-around.
module tb_stepper_axis_driver;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic [31:0] xSpeed, xDirection, ySpeed, yDirection;
    logic        zero_pos;

    logic               step_x, step_y, dir_x, dir_y, busy_x, busy_y, limit_x, limit_y;
    logic signed [15:0] pos_x, pos_y;

    logic              n_step_x, n_step_y, n_dir_x, n_dir_y, n_busy_x, n_busy_y;
    logic              n_limit_x, n_limit_y;
    logic signed [3:0] n_pos_x, n_pos_y;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clock = ~clock;

    stepper_axis_driver #(.POS_LIMIT(3)) dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .xSpeed(xSpeed), .xDirection(xDirection), .ySpeed(ySpeed), .yDirection(yDirection),
        .zero_pos(zero_pos),
        .step_x(step_x), .step_y(step_y), .dir_x(dir_x), .dir_y(dir_y),
        .busy_x(busy_x), .busy_y(busy_y), .pos_x(pos_x), .pos_y(pos_y),
        .limit_x(limit_x), .limit_y(limit_y)
    );

    stepper_axis_driver #(.POS_W(4), .POS_LIMIT(3)) dut_narrow (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .xSpeed(xSpeed), .xDirection(xDirection), .ySpeed(ySpeed), .yDirection(yDirection),
        .zero_pos(zero_pos),
        .step_x(n_step_x), .step_y(n_step_y), .dir_x(n_dir_x), .dir_y(n_dir_y),
        .busy_x(n_busy_x), .busy_y(n_busy_y), .pos_x(n_pos_x), .pos_y(n_pos_y),
        .limit_x(n_limit_x), .limit_y(n_limit_y)
    );

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        ctrl_reset_n = 1'b0;
        xSpeed = 0; xDirection = 0; ySpeed = 0; yDirection = 0; zero_pos = 0;
        tick();
        tick();
        ctrl_reset_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        ctrl_reset_n = 1'b0;
        check_eq("rst_step_x", 32'(step_x), 0);
        check_eq("rst_dir_x", 32'(dir_x), 0);
        check_eq("rst_busy_x", 32'(busy_x), 0);
        check_eq("rst_pos_x", 32'(pos_x), 0);
        check_eq("rst_limit_x", 32'(limit_x), 0);
        check_eq("rst_busy_y", 32'(busy_y), 0);

        // Speed 15, negative: step one clock later, 2 high, period 4, pos -1,-2,-3
        ctrl_reset_n = 1'b1;
        xSpeed = 15; xDirection = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_eq($sformatf("s15_step_k%0d", k), 32'(step_x), ((k - 1) % 4) < 2 ? 1 : 0);
            check_eq($sformatf("s15_pos_k%0d", k), 32'(pos_x), -((k - 1) / 4 + 1));
            check_eq($sformatf("s15_dir_k%0d", k), 32'(dir_x), 0);
        end
        // Stop during PULSE: pulse and gap finish, then idle
        xSpeed = 0;
        for (int k = 10; k <= 18; k++) begin
            tick();
            check_eq($sformatf("stop_step_k%0d", k), 32'(step_x), (k == 10) ? 1 : 0);
            check_eq($sformatf("stop_busy_k%0d", k), 32'(busy_x), (k <= 12) ? 1 : 0);
            check_eq($sformatf("stop_pos_k%0d", k), 32'(pos_x), -3);
        end

        // Speed 14, positive from reset: dir after 1 clock, step 3 later, period 8
        do_reset();
        xSpeed = 14; xDirection = 1;
        for (int k = 1; k <= 23; k++) begin
            tick();
            check_eq($sformatf("s14_dir_k%0d", k), 32'(dir_x), 1);
            check_eq($sformatf("s14_step_k%0d", k), 32'(step_x),
                     (k >= 4 && ((k - 4) % 8) < 2) ? 1 : 0);
            check_eq($sformatf("s14_pos_k%0d", k), 32'(pos_x), (k < 4) ? 0 : ((k - 4) / 8 + 1));
        end
        // Direction flip mid-gap: gap completes, dir toggles, 3 low clocks, count down
        xDirection = 0;
        for (int k = 24; k <= 40; k++) begin
            tick();
            check_eq($sformatf("flip_dir_k%0d", k), 32'(dir_x), (k < 28) ? 1 : 0);
            check_eq($sformatf("flip_step_k%0d", k), 32'(step_x),
                     (k == 31 || k == 32 || k == 39 || k == 40) ? 1 : 0);
            check_eq($sformatf("flip_pos_k%0d", k), 32'(pos_x),
                     (k < 31) ? 3 : ((k < 39) ? 2 : 1));
        end

        // zero_pos on an X pulse entry with both axes running; oversized speed clamps
        do_reset();
        xSpeed = 32'h8000_0000; xDirection = 0; ySpeed = 15; yDirection = 1;
        for (int k = 1; k <= 4; k++) tick();
        check_eq("both_pos_x_k4", 32'(pos_x), -1);
        check_eq("both_pos_y_k4", 32'(pos_y), 1);
        check_eq("both_step_y_k4", 32'(step_y), 1);
        zero_pos = 1'b1;
        tick();
        zero_pos = 1'b0;
        check_eq("zero_pos_x", 32'(pos_x), 0);
        check_eq("zero_pos_y", 32'(pos_y), 0);
        check_eq("zero_step_x", 32'(step_x), 1);
        for (int k = 6; k <= 8; k++) tick();
        check_eq("post_zero_pos_x", 32'(pos_x), 0);
        check_eq("post_zero_pos_y", 32'(pos_y), 1);
        check_eq("post_zero_step_y", 32'(step_y), 1);
        // Reset mid-pulse: everything drops on that edge
        ctrl_reset_n = 1'b0;
        tick();
        check_eq("midrst_step_x", 32'(step_x), 0);
        check_eq("midrst_step_y", 32'(step_y), 0);
        check_eq("midrst_dir_y", 32'(dir_y), 0);
        check_eq("midrst_busy_x", 32'(busy_x), 0);
        check_eq("midrst_busy_y", 32'(busy_y), 0);
        check_eq("midrst_pos_y", 32'(pos_y), 0);
        ctrl_reset_n = 1'b1;

        do_reset();
        xSpeed = 15; xDirection = 1;
`ifdef SOFT_LIMIT_EN
        // Soft limit at +3: three steps, then blocked
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_eq($sformatf("lim_pos_k%0d", k), 32'(pos_x), (k < 4) ? 0 : ((k < 8) ? 1 : ((k < 12) ? 2 : 3)));
        end
        check_eq("lim_flag", 32'(limit_x), 1);
        check_eq("lim_busy", 32'(busy_x), 0);
        check_eq("lim_step", 32'(step_x), 0);
        for (int k = 17; k <= 20; k++) tick();
        check_eq("lim_hold_flag", 32'(limit_x), 1);
        check_eq("lim_hold_pos", 32'(pos_x), 3);
        xDirection = 0;
        tick();
        check_eq("lim_clear_flag", 32'(limit_x), 0);
        check_eq("lim_clear_dir", 32'(dir_x), 0);
        for (int k = 22; k <= 24; k++) tick();
        check_eq("lim_back_step", 32'(step_x), 1);
        check_eq("lim_back_pos", 32'(pos_x), 2);
`else
        // Free wrap: 4-bit counter goes 7 -> -8 (0x7 -> 0x8)
        for (int k = 1; k <= 28; k++) tick();
        check_eq("wrap_pre_narrow", 32'(n_pos_x), 7);
        check_eq("wrap_limit_x", 32'(limit_x), 0);
        for (int k = 29; k <= 32; k++) tick();
        check_eq("wrap_narrow", 32'(n_pos_x), -8);
        check_eq("wrap_wide", 32'(pos_x), 8);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/stepper_axis_driver.md
Name: stepper_axis_driver

Overview:
- Consumes the four motion words the register file drives out of r11–r14: ySpeed, yDirection, xSpeed and xDirection.
- Turns those words into step/direction pulse trains for the X and Y stepper drivers.
- Keeps a signed position count for each axis.
- Sits between the processor/register file and the board's motor-driver pins. btn_CENTER (homing) zeroes the position counters.

Parameters:
- BASE_DIV, 4: clocks per speed unit; step period = BASE_DIV*(SPEED_MAX+1-S). Must be > PULSE_W.
- PULSE_W, 2: clocks that step is held high per step.
- DIR_SETUP, 3: clocks dir must be stable before a step edge after a direction change.
- SPEED_MAX, 15: largest effective speed code; larger inputs are clamped to it.
- POS_W, 16: width of each signed position counter.
- POS_LIMIT, 1000: soft-limit magnitude (used only with SOFT_LIMIT_EN).

Ports:
- clock  in  1  system clock, all logic on posedge
- ctrl_reset_n  in  1  synchronous active-low reset
- xSpeed  in  32  X speed code, unsigned; 0 = stop
- xDirection  in  32  X direction; bit0: 1 = positive, 0 = negative; other bits ignored
- ySpeed  in  32  Y speed code
- yDirection  in  32  Y direction, bit0
- zero_pos  in  1  synchronous clear of both position counters
- step_x, step_y  out  1  step pulses, registered
- dir_x, dir_y  out  1  direction pins, registered
- busy_x, busy_y  out  1  high when the axis FSM is not IDLE
- pos_x, pos_y  out  POS_W  signed position counts
- limit_x, limit_y  out  1  soft-limit blocked flag (tied 0 without SOFT_LIMIT_EN)

Behaviour:
- The two axes are identical, independent instances of one FSM. Text below uses X.
- Reset (ctrl_reset_n=0 at posedge): state IDLE; step, dir, busy, limit = 0; pos = 0. Reset mid-pulse drops step on that same edge.
- Effective speed Se = min(xSpeed, SPEED_MAX), computed as a full 32-bit compare.
- Period P = BASE_DIV*(SPEED_MAX+1-Se). P is latched at PULSE entry and is unaffected by speed changes until the next step decision.
- Step decision point: each IDLE cycle and the last GAP cycle. At that point:
  - Se=0 goes to IDLE.
  - Otherwise, if xDirection[0] != dir_x: update dir_x and go to SETUP.
  - Otherwise go to PULSE.
- States:
  - IDLE: step 0, busy 0.
  - SETUP: counts DIR_SETUP cycles, then PULSE. The first step rising edge therefore comes exactly DIR_SETUP clocks after the dir_x edge.
  - PULSE: step=1 for PULSE_W cycles. pos increments (dir 1) or decrements (dir 0) by 1 on the PULSE entry edge.
  - GAP: step=0 for P-PULSE_W cycles, then decision point. Rising step edges are therefore exactly P clocks apart at constant speed.
- Latency:
  - Speed goes nonzero with matching dir: step_x high on the edge after IDLE samples it (1 clock).
  - Speed goes to 0 mid-step: the current PULSE and GAP complete, then IDLE. No truncated pulses.
- Direction change mid-GAP takes effect only at the decision point, never during PULSE.
- Position arithmetic is two's complement, POS_W wide. Wraps (0x7FFF+1 = 0x8000) without SOFT_LIMIT_EN.
- zero_pos sets pos to 0. If zero_pos coincides with a PULSE entry, zero wins (pos=0 and that step is not counted). step_x still pulses.
- The X and Y axes can step on the same clock. There is no arbitration.

Optional Feature:
- Macro: SOFT_LIMIT_EN.
- When defined, at a decision point:
  - If dir=1 and pos >= +POS_LIMIT, or dir=0 and pos <= -POS_LIMIT, the axis goes to IDLE with no pulse and no count, and limit_x=1.
  - limit_x clears at the next decision point whose move is allowed (opposite direction), or on zero_pos or reset.
- When undefined: no limit logic, limit outputs tied 0, and pos wraps freely.

Test Plan:
- Reset, then xSpeed=15, xDirection=0: step_x rises 1 clock later and is high 2 clocks. Rising edges are every 4 clocks. pos_x = -1, -2, -3…; dir_x stays 0.
- xSpeed=14, xDirection=1 from reset: dir_x=1 after 1 clock, and the first step_x edge comes 3 clocks later. Period is 8 clocks, pos_x counts +1 per step.
- Running at speed 15, set xSpeed=0 during PULSE: the pulse completes (2 clocks high), GAP completes, then busy_x=0 and no further steps. pos_x changes by exactly that one step.
- Flip xDirection mid-GAP: the current gap completes, dir_x toggles, step is held low 3 clocks, then pulses resume with pos_x counting the opposite way.
- Assert zero_pos on a PULSE entry edge while both axes run: pos_x=pos_y=0 afterward. Assert ctrl_reset_n=0 mid-pulse: all outputs 0 on the next edge.
- With SOFT_LIMIT_EN and POS_LIMIT=3: xDirection=1, speed 15 gives exactly 3 steps, then limit_x=1 and busy_x=0. Setting xDirection=0 clears limit_x and gives pos_x=2 after the next step. Without the macro, preload pos to 0x7FFF, one + step gives 0x8000.
